// File: rtl/fifo_transpose_skew_if.sv
// fifo_transpose_skew_if: tile load and skewed per-lane drain bus.
interface fifo_transpose_skew_if #(
    parameter int BITS  = 64,
    parameter int DEPTH = 8,
    parameter int LANES = 8
);
    logic                                  load;
    logic                                  ld_ready;
    logic [LANES-1:0][DEPTH-1:0][BITS-1:0] d;
    logic                                  en;
    logic                                  flush;
    logic [LANES-1:0][BITS-1:0]            q;
    logic [LANES-1:0]                      q_valid;
    logic                                  busy;
    logic                                  done;
    modport master (output load, d, en, flush, input ld_ready, q, q_valid, busy, done);
    modport slave (input load, d, en, flush, output ld_ready, q, q_valid, busy, done);
endinterface

// File: rtl/fifo_transpose_skew.sv
// fifo_transpose_skew: parallel-load a LANES x DEPTH tile, drain it as a diagonal wavefront
// with lane l delayed by l*SKEW steps.
module fifo_transpose_skew #(
    parameter int              BITS  = 64,
    parameter int              DEPTH = 8,
    parameter int              LANES = 8,
    parameter int              SKEW  = 1,
    parameter logic [BITS-1:0] PAD   = '0
) (
    input logic                  clk,
    input logic                  rst,
    fifo_transpose_skew_if.slave io
);
    localparam int S  = DEPTH + (LANES - 1) * SKEW;
    localparam int CW = $clog2(S);
    localparam int KW = $clog2(DEPTH);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t                                state_q, state_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [LANES-1:0][DEPTH-1:0][BITS-1:0] tile_q, tile_d;
    logic                                  done_q, done_d;
    logic                                  take, last, hit;
    int                                    idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            done_q  <= done_d;
        end
    end
    // flush outranks both load (IDLE) and en (DRAIN)
    always_comb begin
        take    = state_q == IDLE && io.load && !io.flush;
        last    = cnt_q == CW'(S - 1);
        state_d = io.flush ? IDLE
                : state_q == IDLE ? (io.load ? DRAIN : IDLE)
                : (io.en && last) ? IDLE : DRAIN;
        cnt_d   = (take || io.flush || (state_q == DRAIN && io.en && last)) ? '0
                : (state_q == DRAIN && io.en) ? cnt_q + 1'b1 : cnt_q;
        done_d  = state_q == DRAIN && !io.flush && io.en && last;
        tile_d  = take ? io.d : tile_q;
    end
    // idx is a signed int so lanes still waiting on their skew never alias into the tile
    always_comb begin
        io.ld_ready = state_q == IDLE;
        io.busy     = state_q == DRAIN;
        io.done     = done_q;
        io.q        = {LANES{PAD}};
        io.q_valid  = '0;
        idx         = 0;
        hit         = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            idx           = int'(cnt_q) - l * SKEW;
            hit           = state_q == DRAIN && idx >= 0 && idx < DEPTH;
            io.q_valid[l] = hit;
            io.q[l]       = hit ? tile_q[l][idx[KW-1:0]] : PAD;
        end
    end
endmodule

// File: tb/tb_fifo_transpose_skew.sv
// tb_fifo_transpose_skew: scoreboard bench, SKEW=1 and SKEW=0 instances with hand-computed steps.
module tb_fifo_transpose_skew;
    typedef struct packed {
        logic        bsy;
        logic        dn;
        logic        rdy;
        logic [23:0] q;
        logic [2:0]  v;
    } exp_t;
    localparam exp_t DONE_REC = {1'b0, 1'b1, 1'b1, 24'hFFFFFF, 3'b000};
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel, load, en, flush;
    logic [2:0][3:0][7:0] dd, base;
    int                checks = 0;
    int                errors = 0;
    exp_t              sb1[$], sb0[$];
    exp_t              g1, g0, m1, m0;
    logic [23:0]       t1 [6] = '{24'hFFFF00, 24'hFF1001, 24'h201102, 24'h211203, 24'h2213FF, 24'h23FFFF};
    logic [2:0]        v1 [6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
    logic [23:0]       t0 [4] = '{24'h201000, 24'h211101, 24'h221202, 24'h231303};
    always #5 clk = ~clk;
    fifo_transpose_skew_if #(.BITS(8), .DEPTH(4), .LANES(3)) if1 ();
    fifo_transpose_skew_if #(.BITS(8), .DEPTH(4), .LANES(3)) if0 ();
    assign if1.load  = sel & load;
    assign if1.en    = sel & en;
    assign if1.flush = sel & flush;
    assign if1.d     = dd;
    assign if0.load  = !sel & load;
    assign if0.en    = !sel & en;
    assign if0.flush = !sel & flush;
    assign if0.d     = dd;
    fifo_transpose_skew #(.BITS(8), .DEPTH(4), .LANES(3), .SKEW(1), .PAD(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .io(if1));
    fifo_transpose_skew #(.BITS(8), .DEPTH(4), .LANES(3), .SKEW(0), .PAD(8'hFF)) dut0 (
        .clk(clk), .rst(rst), .io(if0));
    assign g1 = {if1.busy, if1.done, if1.ld_ready, if1.q, if1.q_valid};
    assign g0 = {if0.busy, if0.done, if0.ld_ready, if0.q, if0.q_valid};
    always @(negedge clk) begin
        if (!rst && (if1.busy || if1.done)) begin
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL mon_skew1 unexpected output got %h want nothing", g1);
            end else begin
                m1 = sb1.pop_front();
                if (g1 !== m1) begin
                    errors++;
                    $display("FAIL mon_skew1 got %h want %h", g1, m1);
                end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && (if0.busy || if0.done)) begin
            checks++;
            if (sb0.size() == 0) begin
                errors++;
                $display("FAIL mon_skew0 unexpected output got %h want nothing", g0);
            end else begin
                m0 = sb0.pop_front();
                if (g0 !== m0) begin
                    errors++;
                    $display("FAIL mon_skew0 got %h want %h", g0, m0);
                end
            end
        end
    end
    function automatic exp_t busy_rec(input int s, input bit sk);
        exp_t r;
        r = '0;
        r.bsy = 1'b1;
        if (sk) begin
            r.q = t1[s];
            r.v = v1[s];
        end else begin
            r.q = t0[s];
            r.v = 3'b111;
        end
        return r;
    endfunction
    task automatic cyc(input bit push, input exp_t r);
        @(posedge clk);
        #1;
        if (push) begin
            if (sel) sb1.push_back(r);
            else sb0.push_back(r);
        end
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask
    task automatic chk_idle(input string nm);
        chk({nm, "_q"}, {8'h0, if1.q}, 32'hFFFFFF);
        chk({nm, "_v"}, {29'h0, if1.q_valid}, 32'h0);
        chk({nm, "_busy"}, {31'h0, if1.busy}, 32'h0);
        chk({nm, "_rdy"}, {31'h0, if1.ld_ready}, 32'h1);
        chk({nm, "_done"}, {31'h0, if1.done}, 32'h0);
    endtask
    task automatic full_drain1();
        load = 1'b1;
        cyc(1, busy_rec(0, 1));
        load = 1'b0;
        en = 1'b1;
        for (int s = 1; s < 6; s++) cyc(1, busy_rec(s, 1));
        cyc(1, DONE_REC);
        en = 1'b0;
        cyc(0, DONE_REC);
    endtask
    initial begin
        for (int l = 0; l < 3; l++)
            for (int k = 0; k < 4; k++) base[l][k] = 8'(16 * l + k);
        sel = 1'b1; load = 1'b0; en = 1'b0; flush = 1'b0; dd = base;
        #12;
        chk_idle("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        full_drain1();
        load = 1'b1;
        en = 1'b1;
        cyc(1, busy_rec(0, 1));
        load = 1'b0;
        cyc(1, busy_rec(1, 1));
        cyc(1, busy_rec(2, 1));
        en = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, busy_rec(2, 1));
        en = 1'b1;
        for (int s = 3; s < 6; s++) cyc(1, busy_rec(s, 1));
        cyc(1, DONE_REC);
        en = 1'b0;
        cyc(0, DONE_REC);
        // load and new d held high through the whole drain must not disturb it
        load = 1'b1;
        cyc(1, busy_rec(0, 1));
        dd = {12{8'hAA}};
        en = 1'b1;
        for (int s = 1; s < 6; s++) cyc(1, busy_rec(s, 1));
        cyc(1, DONE_REC);
        load = 1'b0;
        en = 1'b0;
        dd = base;
        cyc(0, DONE_REC);
        load = 1'b1;
        en = 1'b1;
        cyc(1, busy_rec(0, 1));
        load = 1'b0;
        for (int s = 1; s < 4; s++) cyc(1, busy_rec(s, 1));
        flush = 1'b1;
        cyc(0, DONE_REC);
        flush = 1'b0;
        en = 1'b0;
        #3 chk_idle("flush");
        cyc(0, DONE_REC);
        load = 1'b1;
        en = 1'b1;
        cyc(1, busy_rec(0, 1));
        load = 1'b0;
        for (int s = 1; s < 4; s++) cyc(1, busy_rec(s, 1));
        cyc(0, DONE_REC);
        #1;
        chk("step4_q", {8'h0, if1.q}, {8'h0, t1[4]});
        chk("step4_v", {29'h0, if1.q_valid}, {29'h0, v1[4]});
        #1 rst = 1'b1;
        en = 1'b0;
        #1 chk_idle("async_rst");
        @(posedge clk);
        #3 rst = 1'b0;
        #2;
        full_drain1();
        sel = 1'b0;
        load = 1'b1;
        en = 1'b1;
        cyc(1, busy_rec(0, 0));
        load = 1'b0;
        for (int s = 1; s < 4; s++) cyc(1, busy_rec(s, 0));
        cyc(1, DONE_REC);
        load = 1'b1;
        cyc(1, busy_rec(0, 0));
        load = 1'b0;
        for (int s = 1; s < 4; s++) cyc(1, busy_rec(s, 0));
        cyc(1, DONE_REC);
        en = 1'b0;
        cyc(0, DONE_REC);
        cyc(0, DONE_REC);
        chk("sb_skew1_empty", sb1.size(), 0);
        chk("sb_skew0_empty", sb0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
